// File: rtl/anton_neopixel_stream_decoder_if.sv
// Pixel-buffer write port driven by the NeoPixel stream decoder.
interface anton_neopixel_stream_decoder_if #(
  parameter int unsigned BUFFER_BITS = 3
);
  logic                   pixelWrite;
  logic [BUFFER_BITS-1:0] pixelAddr;
  logic [23:0]            pixelData;

  modport master (output pixelWrite, output pixelAddr, output pixelData);
  modport slave  (input  pixelWrite, input  pixelAddr, input  pixelData);
endinterface

// File: rtl/anton_neopixel_stream_decoder.sv
// WS2812-style stream decoder: measures high-pulse widths at 8 ticks/bit, assembles
// 24-bit MSB-first pixels into a pixel buffer and flags the latch gap as frame end.
module anton_neopixel_stream_decoder #(
  parameter int unsigned BUFFER_END    = 7,
  parameter int unsigned ONE_THRESHOLD = 4,
  parameter int unsigned MAX_HIGH      = 7,
  parameter int unsigned RESET_TICKS   = 320,
  localparam int unsigned BUFFER_BITS  = $clog2(BUFFER_END + 1),
  localparam int unsigned COUNT_BITS   = $clog2(BUFFER_END + 2)
) (
  input  logic                   clk6_4mhz,
  input  logic                   syncReset,
  input  logic                   enable,
  input  logic                   regCtrl32bit,
  input  logic                   streamInput,
  anton_neopixel_stream_decoder_if.master pix,
  output logic                   frameDone,
  output logic [COUNT_BITS-1:0]  pixelCount,
  output logic                   overflow,
  output logic                   bitError,
  output logic [1:0]             state
);

  localparam int unsigned HCNT_W = 4;
  localparam int unsigned LCNT_W = 12;
  localparam int unsigned BIT_W  = 5;
  // Two spare bits let the address step past BUFFER_END without wrapping.
  localparam int unsigned ADDR_W = BUFFER_BITS + 2;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_e;

  logic                   sync1_q;
  logic                   s_q;
  logic                   s_prev_q;
  state_e                 state_q,       state_d;
  logic [HCNT_W-1:0]      high_cnt_q,    high_cnt_d;
  logic [LCNT_W-1:0]      low_cnt_q,     low_cnt_d;
  logic [BIT_W-1:0]       bit_idx_q,     bit_idx_d;
  logic [23:0]            shift_q,       shift_d;
  logic [ADDR_W-1:0]      addr_q,        addr_d;
  logic [COUNT_BITS-1:0]  frame_cnt_q,   frame_cnt_d;
  logic                   mode32_q,      mode32_d;
  logic                   pixel_write_q, pixel_write_d;
  logic [BUFFER_BITS-1:0] pixel_addr_q,  pixel_addr_d;
  logic [23:0]            pixel_data_q,  pixel_data_d;
  logic                   frame_done_q,  frame_done_d;
  logic [COUNT_BITS-1:0]  pixel_count_q, pixel_count_d;
  logic                   overflow_q,    overflow_d;
  logic                   bit_error_q,   bit_error_d;

  logic                   rise_c;
  logic                   fall_c;
  logic                   new_bit_c;
  logic [23:0]            shift_next_c;
  logic [ADDR_W-1:0]      addr_last_c;
  logic                   in_range_c;
  logic [ADDR_W-1:0]      addr_step_c;

  // Edge detection and pixel address range test.
  always_comb begin
    rise_c       = s_q & ~s_prev_q;
    fall_c       = ~s_q & s_prev_q;
    new_bit_c    = (32'(high_cnt_q) >= ONE_THRESHOLD);
    shift_next_c = {shift_q[22:0], new_bit_c};
    addr_last_c  = mode32_q ? (addr_q | ADDR_W'(3)) : addr_q;
    in_range_c   = (32'(addr_last_c) <= BUFFER_END);
    addr_step_c  = mode32_q ? ADDR_W'(4) : ADDR_W'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    high_cnt_d    = high_cnt_q;
    low_cnt_d     = low_cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    addr_d        = addr_q;
    frame_cnt_d   = frame_cnt_q;
    mode32_d      = mode32_q;
    pixel_write_d = 1'b0;
    pixel_addr_d  = pixel_addr_q;
    pixel_data_d  = pixel_data_q;
    frame_done_d  = 1'b0;
    pixel_count_d = pixel_count_q;
    overflow_d    = overflow_q;
    bit_error_d   = 1'b0;

    // Saturating run-length counters, each cleared by the opposite level.
    if (s_q) begin
      low_cnt_d = '0;
      if (rise_c)
        high_cnt_d = HCNT_W'(1);
      else if (high_cnt_q != '1)
        high_cnt_d = high_cnt_q + HCNT_W'(1);
    end else begin
      high_cnt_d = '0;
      if (fall_c)
        low_cnt_d = LCNT_W'(1);
      else if (low_cnt_q != '1)
        low_cnt_d = low_cnt_q + LCNT_W'(1);
    end

    case (state_q)
      ST_SYNC: begin
        if (!s_q && 32'(low_cnt_d) >= RESET_TICKS)
          state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (rise_c) begin
          state_d     = ST_HIGH;
          mode32_d    = regCtrl32bit;
          addr_d      = '0;
          bit_idx_d   = '0;
          frame_cnt_d = '0;
          overflow_d  = 1'b0;
        end
      end

      ST_HIGH: begin
        if (s_q && 32'(high_cnt_d) > MAX_HIGH) begin
          bit_error_d = 1'b1;
          state_d     = ST_SYNC;
        end else if (fall_c) begin
          shift_d = shift_next_c;
          state_d = ST_LOW;
          if (bit_idx_q == BIT_W'(23)) begin
            bit_idx_d    = '0;
            pixel_data_d = shift_next_c;
            pixel_addr_d = addr_q[BUFFER_BITS-1:0];
            if (in_range_c) begin
              pixel_write_d = 1'b1;
              addr_d        = addr_q + addr_step_c;
              frame_cnt_d   = frame_cnt_q + COUNT_BITS'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end
      end

      ST_LOW: begin
        if (rise_c) begin
          state_d = ST_HIGH;
        end else if (32'(low_cnt_d) >= RESET_TICKS) begin
          state_d       = ST_IDLE;
          frame_done_d  = 1'b1;
          pixel_count_d = frame_cnt_q;
          // A frame ending mid-pixel drops the partial pixel.
          if (bit_idx_q != '0) begin
            bit_error_d = 1'b1;
            bit_idx_d   = '0;
            shift_d     = '0;
          end
        end
      end

      default: state_d = ST_SYNC;
    endcase

    if (!enable) begin
      state_d       = ST_SYNC;
      high_cnt_d    = '0;
      low_cnt_d     = '0;
      bit_idx_d     = '0;
      shift_d       = '0;
      addr_d        = '0;
      frame_cnt_d   = '0;
      pixel_write_d = 1'b0;
      frame_done_d  = 1'b0;
      bit_error_d   = 1'b0;
    end
  end

  always_ff @(posedge clk6_4mhz) begin
    if (syncReset) begin
      sync1_q       <= 1'b0;
      s_q           <= 1'b0;
      s_prev_q      <= 1'b0;
      state_q       <= ST_SYNC;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      addr_q        <= '0;
      frame_cnt_q   <= '0;
      mode32_q      <= 1'b0;
      pixel_write_q <= 1'b0;
      pixel_addr_q  <= '0;
      pixel_data_q  <= '0;
      frame_done_q  <= 1'b0;
      pixel_count_q <= '0;
      overflow_q    <= 1'b0;
      bit_error_q   <= 1'b0;
    end else begin
      sync1_q       <= streamInput;
      s_q           <= sync1_q;
      s_prev_q      <= s_q;
      state_q       <= state_d;
      high_cnt_q    <= high_cnt_d;
      low_cnt_q     <= low_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      addr_q        <= addr_d;
      frame_cnt_q   <= frame_cnt_d;
      mode32_q      <= mode32_d;
      pixel_write_q <= pixel_write_d;
      pixel_addr_q  <= pixel_addr_d;
      pixel_data_q  <= pixel_data_d;
      frame_done_q  <= frame_done_d;
      pixel_count_q <= pixel_count_d;
      overflow_q    <= overflow_d;
      bit_error_q   <= bit_error_d;
    end
  end

  assign pix.pixelWrite = pixel_write_q;
  assign pix.pixelAddr  = pixel_addr_q;
  assign pix.pixelData  = pixel_data_q;
  assign frameDone      = frame_done_q;
  assign pixelCount     = pixel_count_q;
  assign overflow       = overflow_q;
  assign bitError       = bit_error_q;
  assign state          = state_q;

endmodule
